// File: rtl/huffman_encoder_pkg.sv
// rtl/huffman_encoder_pkg.sv - shared types and sizes for the 3-symbol Huffman encoder
package huff_pkg;

    localparam int MAX_CHAR_COUNT = 3;
    localparam int BIT_WIDTH      = 2;

    typedef enum logic [2:0] {
        LOAD,
        SORT,
        BUILD,
        ENCODE,
        OUTPUT
    } state_t;

    typedef struct packed {
        logic [4:0] chr;
        logic [2:0] freq;
        logic [1:0] idx;
    } symbol_t;

    typedef struct packed {
        logic [BIT_WIDTH-1:0] mask;
        logic [BIT_WIDTH-1:0] value;
    } code_t;

endpackage

// File: rtl/huffman_encoder_if.sv
// rtl/huffman_encoder_if.sv - 12-bit input and output buses of the encoder
interface huffman_encoder_if;

    logic [11:0] io_in;
    logic [11:0] io_out;

    modport master (output io_in, input io_out);
    modport slave  (input io_in, output io_out);

endinterface

// File: rtl/huffman_encoder_sort3.sv
// rtl/huffman_encoder_sort3.sv - combinational stable ascending sort of three symbols
module huff_sort3
    import huff_pkg::*;
(
    input  symbol_t in0,
    input  symbol_t in1,
    input  symbol_t in2,
    output symbol_t out0,
    output symbol_t out1,
    output symbol_t out2
);

    symbol_t a0, a1, b1, b2;

    // Three adjacent compare-swaps; swapping only on strictly greater keeps equal keys in input order
    always_comb begin
        a0 = in0;
        a1 = in1;
        if (in0.freq > in1.freq) begin
            a0 = in1;
            a1 = in0;
        end
        b1 = a1;
        b2 = in2;
        if (a1.freq > in2.freq) begin
            b1 = in2;
            b2 = a1;
        end
        out0 = a0;
        out1 = b1;
        out2 = b2;
        if (a0.freq > b1.freq) begin
            out0 = b1;
            out1 = a0;
        end
    end

endmodule

// File: rtl/huffman_encoder.sv
// rtl/huffman_encoder.sv - loads three beats, builds a Huffman code table, streams six words
module huffman_encoder
    import huff_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    huffman_encoder_if.slave   bus
);

    state_t     state, state_nxt;
    logic [1:0] beat_cnt;
    logic [2:0] word_cnt;
    logic [4:0] char_q [MAX_CHAR_COUNT];
    logic [2:0] freq_q [MAX_CHAR_COUNT];
    symbol_t    s_q    [MAX_CHAR_COUNT];
    code_t      code_q [MAX_CHAR_COUNT];
    logic       n_root;
    logic [11:0] out_q;

    symbol_t    in_sym [MAX_CHAR_COUNT];
    symbol_t    srt0, srt1, srt2;
    logic [3:0] n_freq;
    logic       beat_valid;
    logic [1:0] out_sym;

    assign beat_valid = bus.io_in[11];
    assign n_freq     = {1'b0, s_q[0].freq} + {1'b0, s_q[1].freq};
    assign out_sym    = word_cnt[2:1];
    assign bus.io_out = out_q;

    // Pack the loaded table into symbols tagged with their input position
    always_comb begin
        for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
            in_sym[i] = '{chr: char_q[i], freq: freq_q[i], idx: 2'(i)};
        end
    end

    huff_sort3 u_sort (
        .in0  (in_sym[0]),
        .in1  (in_sym[1]),
        .in2  (in_sym[2]),
        .out0 (srt0),
        .out1 (srt1),
        .out2 (srt2)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    // Next-state: one cycle each for sort, build and encode, six for output
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (beat_valid && beat_cnt == 2'd2) state_nxt = SORT;
            SORT:    state_nxt = BUILD;
            BUILD:   state_nxt = ENCODE;
            ENCODE:  state_nxt = OUTPUT;
            OUTPUT:  if (word_cnt == 3'd5) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Datapath: capture beats, latch sorted order, pick root bit, assign codes, emit words
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            word_cnt <= '0;
            n_root   <= 1'b0;
            out_q    <= '0;
            for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
                char_q[i] <= '0;
                freq_q[i] <= '0;
                s_q[i]    <= '0;
                code_q[i] <= '0;
            end
        end else begin
            out_q <= '0;
            case (state)
                LOAD: begin
                    if (beat_valid) begin
                        char_q[beat_cnt] <= bus.io_in[4:0];
                        freq_q[beat_cnt] <= bus.io_in[10:8];
                        beat_cnt         <= (beat_cnt == 2'd2) ? 2'd0 : beat_cnt + 2'd1;
                    end
                end
                SORT: begin
                    s_q[0] <= srt0;
                    s_q[1] <= srt1;
                    s_q[2] <= srt2;
                end
                BUILD: begin
                    // Node N takes root bit 0 only when strictly lighter than leaf s2
                    n_root <= !(n_freq < {1'b0, s_q[2].freq});
                end
                ENCODE: begin
                    code_q[s_q[0].idx] <= '{mask: 2'b11, value: {n_root, 1'b0}};
                    code_q[s_q[1].idx] <= '{mask: 2'b11, value: {n_root, 1'b1}};
                    code_q[s_q[2].idx] <= '{mask: 2'b01, value: {1'b0, ~n_root}};
                    word_cnt           <= '0;
                end
                OUTPUT: begin
                    if (word_cnt[0] == 1'b0)
                        out_q <= {3'b000, 1'b1, 3'b000, char_q[out_sym]};
                    else
                        out_q <= {3'b000, 1'b1, 2'b00, code_q[out_sym].mask,
                                  2'b00, code_q[out_sym].value};
                    word_cnt <= (word_cnt == 3'd5) ? 3'd0 : word_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_encoder.sv
// tb/tb_huffman_encoder.sv - directed self-checking bench for huffman_encoder
module tb_huffman_encoder;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;

    huffman_encoder_if bus ();

    huffman_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %03h expected %03h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] cw(input logic [7:0] c);
        return {3'b000, 1'b1, 3'b000, c[4:0]};
    endfunction

    function automatic logic [11:0] mw(input logic [1:0] m, input logic [1:0] v);
        return {3'b000, 1'b1, 2'b00, m, 2'b00, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c0, c1, c2, input logic [2:0] f0, f1, f2, input int gap);
        bus.io_in = {1'b1, f0, c0};
        tick();
        for (int g = 0; g < gap; g++) begin bus.io_in = {1'b0, 3'd7, 8'h7f}; tick(); end
        bus.io_in = {1'b1, f1, c1};
        tick();
        for (int g = 0; g < gap; g++) begin bus.io_in = 12'h0ff; tick(); end
        bus.io_in = {1'b1, f2, c2};
        tick();
        bus.io_in = '0;
    endtask

    // Checks latency from the third beat, words_to_check words, and the idle word after
    task automatic expect_out(input string tag, input logic [11:0] w [6], input int words_to_check,
                              input bit junk);
        if (junk) bus.io_in = {1'b1, 3'd5, 8'h71};
        for (int k = 0; k < 3; k++) begin tick(); chk({tag, "_pre"}, bus.io_out, 12'h000); end
        for (int k = 0; k < words_to_check; k++) begin
            tick();
            chk($sformatf("%s_w%0d", tag, k), bus.io_out, w[k]);
        end
        bus.io_in = '0;
        if (words_to_check == 6) begin
            tick();
            chk({tag, "_post"}, bus.io_out, 12'h000);
        end
    endtask

    logic [11:0] w_abc123 [6];
    logic [11:0] w_xyz411 [6];
    logic [11:0] w_abc222 [6];
    logic [11:0] w_cab000 [6];
    logic [11:0] w_dog775 [6];

    initial begin
        w_abc123 = '{cw("a"), mw(2'b11, 2'b10), cw("b"), mw(2'b11, 2'b11), cw("c"), mw(2'b01, 2'b00)};
        w_xyz411 = '{cw("x"), mw(2'b01, 2'b01), cw("y"), mw(2'b11, 2'b00), cw("z"), mw(2'b11, 2'b01)};
        w_abc222 = w_abc123;
        w_cab000 = '{cw("c"), mw(2'b11, 2'b10), cw("a"), mw(2'b11, 2'b11), cw("b"), mw(2'b01, 2'b00)};
        w_dog775 = '{cw("d"), mw(2'b11, 2'b11), cw("o"), mw(2'b01, 2'b00), cw("g"), mw(2'b11, 2'b10)};

        bus.io_in = '0;
        reset     = 1'b1;
        tick();
        tick();
        chk("reset_out", bus.io_out, 12'h000);
        reset = 1'b0;
        tick();
        chk("idle_out", bus.io_out, 12'h000);

        // Explicit first word check: abc 1,2,3 -> 0x101
        send("a", "b", "c", 3'd1, 3'd2, 3'd3, 0);
        expect_out("abc123", w_abc123, 6, 1'b0);

        send("x", "y", "z", 3'd4, 3'd1, 3'd1, 0);
        expect_out("xyz411", w_xyz411, 6, 1'b0);

        send("a", "b", "c", 3'd2, 3'd2, 3'd2, 0);
        expect_out("abc222", w_abc222, 6, 1'b0);

        send("x", "y", "z", 3'd4, 3'd1, 3'd1, 2);
        expect_out("xyz_gap", w_xyz411, 6, 1'b0);

        // Abort during output after word 2, then a clean vector
        send("x", "y", "z", 3'd4, 3'd1, 3'd1, 0);
        expect_out("abort", w_xyz411, 3, 1'b0);
        reset = 1'b1;
        tick();
        chk("abort_out", bus.io_out, 12'h000);
        reset = 1'b0;
        send("a", "b", "c", 3'd1, 3'd2, 3'd3, 0);
        expect_out("after_abort", w_abc123, 6, 1'b0);

        // Back-to-back stream with valid junk held on io_in while not in LOAD
        send("a", "b", "c", 3'd1, 3'd2, 3'd3, 0);
        expect_out("s0", w_abc123, 6, 1'b1);
        send("x", "y", "z", 3'd4, 3'd1, 3'd1, 0);
        expect_out("s1", w_xyz411, 6, 1'b1);
        send("a", "b", "c", 3'd2, 3'd2, 3'd2, 0);
        expect_out("s2", w_abc222, 6, 1'b1);
        send("c", "a", "b", 3'd0, 3'd0, 3'd0, 0);
        expect_out("s3", w_cab000, 6, 1'b1);
        send("d", "o", "g", 3'd7, 3'd7, 3'd5, 0);
        expect_out("s4", w_dog775, 6, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
